// File: rtl/mips16_pkg.sv
// Shared encodings for the 16-bit MIPS multi-cycle controller: state codes,
// opcodes, ALU/mux select codes and the per-cycle control word.
package mips16_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    function automatic logic op_is_rtype(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath/memory bundle. The master side is the controller,
// which owns the memory request and every datapath control.
interface mips_multicycle_control_if;
    logic        run;
    logic [3:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        MemRead;
    logic        MemWrite;
    logic        IorD;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCWriteCond;
    logic [1:0]  PCSource;
    logic [1:0]  ALUOp;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        RegWrite;
    logic        RegDst;
    logic        MemtoReg;
    logic        illegal;
    logic [15:0] instr_count;
    logic [3:0]  state;

    modport master (
        input  run, opcode, zero, mem_ready,
        output mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, MemtoReg,
               illegal, instr_count, state
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, MemtoReg,
               illegal, instr_count, state
    );
endinterface

// File: rtl/mc_output_decode.sv
// Control word decode: pure function of the current state, except that the
// FETCH-cycle IR/PC writes are qualified by mem_ready.
module mc_output_decode
    import mips16_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_b = ALUSRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = ALUSRCB_IMMSH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                ctrl.mem_req  = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUSRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle sequencer for the 16-bit MIPS datapath: state register,
// dispatch, and retired-instruction counter.
//
// state      | meaning
// IDLE       | waiting for run
// FETCH      | read instruction, PC += 4 on the ready cycle
// DECODE     | branch target into ALUOut, dispatch on opcode
// MEM_ADDR   | effective address A + sext(imm)
// MEM_READ   | lw data read, holds for mem_ready
// MEM_WB     | lw write-back to rt
// MEM_WRITE  | sw data write, holds for mem_ready
// R_EXEC     | A op B using funct
// R_WB       | R-type write-back to rd
// BRANCH     | compare A - B, conditional PC load from ALUOut
// ADDI_EXEC  | A + sext(imm)
// ADDI_WB    | addi write-back to rt
module mips_multicycle_control
    import mips16_pkg::*;
(
    input logic                        clock,
    input logic                        reset_n,
    mips_multicycle_control_if.master  bus
);

    state_t      state_q;
    logic [15:0] instr_count_q;
    ctrl_t       ctrl;
    logic        retire;

    mc_output_decode u_decode (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    always_comb begin
        retire = 1'b0;
        case (state_q)
            ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_ADDI_WB: retire = 1'b1;
            ST_MEM_WRITE:                              retire = bus.mem_ready;
            default:                                   retire = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            instr_count_q <= '0;
        end else begin
            if (retire)
                instr_count_q <= instr_count_q + 16'd1;
            case (state_q)
                ST_IDLE:      if (bus.run) state_q <= ST_FETCH;
                ST_FETCH:     if (bus.mem_ready) state_q <= ST_DECODE;
                ST_DECODE: begin
                    if (op_is_rtype(bus.opcode))
                        state_q <= ST_R_EXEC;
                    else if (bus.opcode == OP_LW || bus.opcode == OP_SW)
                        state_q <= ST_MEM_ADDR;
                    else if (bus.opcode == OP_ADDI)
                        state_q <= ST_ADDI_EXEC;
                    else if (bus.opcode == OP_BEQ)
                        state_q <= ST_BRANCH;
                    else
                        state_q <= ST_FETCH;
                end
                ST_MEM_ADDR:  state_q <= (bus.opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
                ST_MEM_READ:  if (bus.mem_ready) state_q <= ST_MEM_WB;
                ST_MEM_WB:    state_q <= ST_FETCH;
                ST_MEM_WRITE: if (bus.mem_ready) state_q <= ST_FETCH;
                ST_R_EXEC:    state_q <= ST_R_WB;
                ST_R_WB:      state_q <= ST_FETCH;
                ST_BRANCH:    state_q <= ST_FETCH;
                ST_ADDI_EXEC: state_q <= ST_ADDI_WB;
                ST_ADDI_WB:   state_q <= ST_FETCH;
                default:      state_q <= ST_IDLE;
            endcase
        end
    end

    // Undefined opcodes are flagged while DECODE is presenting them.
    assign bus.illegal = (state_q == ST_DECODE) &&
                         !(op_is_rtype(bus.opcode) || bus.opcode == OP_LW ||
                           bus.opcode == OP_SW || bus.opcode == OP_ADDI ||
                           bus.opcode == OP_BEQ);

    assign bus.mem_req     = ctrl.mem_req;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IorD        = ctrl.iord;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.instr_count = instr_count_q;
    assign bus.state       = state_q;

endmodule
